burst_ram_arbiter: RTL and testbench

- Shares one BurstRAM between two cache-side requesters: port 0 for the data cache and port 1 for the instruction cache.
- Each port has a BurstRAM-style interface. The arbiter grants whole bursts, holds a pending command from the losing port, and streams write beats.
- Sits between the caches and the BurstRAM controller in the SoC top level.

---
 rtl/burst_ram_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_burst_ram_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_ram_arbiter.sv
// Whole-burst arbiter sharing one BurstRAM between port 0 (data cache) and port 1 (instruction cache).
// Define BURST_ARB_FIXED_PRIO_EN to give port 0 fixed priority; the default build is round-robin.
module burst_ram_arbiter #(
   parameter int RAM_BURST_DATA_COUNT    = 4,
   parameter int RAM_BURST_DATA_BITWIDTH = 64,
   parameter int RAM_DEPTH_BITWIDTH      = 8
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 p0_cmd,
   input  logic                                 p0_cmd_en,
   input  logic [RAM_DEPTH_BITWIDTH-1:0]        p0_addr,
   input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   p0_wr_data,
   input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0] p0_data_mask,
   output logic                                 p0_wr_next,
   output logic [RAM_BURST_DATA_BITWIDTH-1:0]   p0_rd_data,
   output logic                                 p0_rd_data_valid,
   output logic                                 p0_busy,
   input  logic                                 p1_cmd,
   input  logic                                 p1_cmd_en,
   input  logic [RAM_DEPTH_BITWIDTH-1:0]        p1_addr,
   input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   p1_wr_data,
   input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0] p1_data_mask,
   output logic                                 p1_wr_next,
   output logic [RAM_BURST_DATA_BITWIDTH-1:0]   p1_rd_data,
   output logic                                 p1_rd_data_valid,
   output logic                                 p1_busy,
   output logic                                 br_cmd,
   output logic                                 br_cmd_en,
   output logic [RAM_DEPTH_BITWIDTH-1:0]        br_addr,
   output logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_wr_data,
   output logic [RAM_BURST_DATA_BITWIDTH/8-1:0] br_data_mask,
   input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_rd_data,
   input  logic                                 br_rd_data_valid,
   input  logic                                 br_busy
);
   localparam int DW = RAM_BURST_DATA_BITWIDTH;
   localparam int AW = RAM_DEPTH_BITWIDTH;
   localparam int MW = RAM_BURST_DATA_BITWIDTH / 8;
   localparam int CW = (RAM_BURST_DATA_COUNT > 1) ? $clog2(RAM_BURST_DATA_COUNT) : 1;
   localparam logic [CW-1:0] LAST = CW'(RAM_BURST_DATA_COUNT - 1);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DRAIN} state_t;

   typedef struct packed {
      logic          cmd;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [MW-1:0] mask;
   } req_t;

   state_t        state_q, state_d;
   logic          owner_q, owner_d;
   logic          last_grant_q, last_grant_d;
   logic [CW-1:0] beat_cnt_q, beat_cnt_d;
   logic          wr_next_q, wr_next_d;
   logic [1:0]    slot_vld_q, slot_vld_d;
   req_t          slot_q [2];
   req_t          slot_d [2];
   logic          br_cmd_q, br_cmd_d, br_cmd_en_q, br_cmd_en_d;
   logic [AW-1:0] br_addr_q, br_addr_d;
   logic [DW-1:0] br_wr_data_q, br_wr_data_d;
   logic [MW-1:0] br_data_mask_q, br_data_mask_d;

   logic [1:0]    cmd_en_in;
   req_t          req_in [2];
   logic [DW-1:0] wr_data_in [2];
   logic          winner;

   assign cmd_en_in     = {p1_cmd_en, p0_cmd_en};
   assign req_in[0]     = '{cmd: p0_cmd, addr: p0_addr, data: p0_wr_data, mask: p0_data_mask};
   assign req_in[1]     = '{cmd: p1_cmd, addr: p1_addr, data: p1_wr_data, mask: p1_data_mask};
   assign wr_data_in[0] = p0_wr_data;
   assign wr_data_in[1] = p1_wr_data;

   always_comb begin
      // NOTE: every *_d starts from its _q (or an idle value) so no branch can infer a latch.
      state_d        = state_q;
      owner_d        = owner_q;
      last_grant_d   = last_grant_q;
      beat_cnt_d     = beat_cnt_q;
      slot_vld_d     = slot_vld_q;
      slot_d         = slot_q;
      wr_next_d      = 1'b0;
      br_cmd_en_d    = 1'b0;
      br_cmd_d       = br_cmd_q;
      br_addr_d      = br_addr_q;
      br_wr_data_d   = br_wr_data_q;
      br_data_mask_d = br_data_mask_q;

`ifdef BURST_ARB_FIXED_PRIO_EN
      winner = ~slot_vld_q[0];
`else
      winner = (&slot_vld_q) ? ~last_grant_q : slot_vld_q[1];
`endif

      // Commands arriving while a port is busy are protocol violations and are dropped.
      for (int i = 0; i < 2; i++) begin
         if (cmd_en_in[i] && !slot_vld_q[i]) begin
            slot_vld_d[i] = 1'b1;
            slot_d[i]     = req_in[i];
         end
      end

      unique case (state_q)
         IDLE: begin
            if (|slot_vld_q && !br_busy) begin
               br_cmd_en_d    = 1'b1;
               br_cmd_d       = slot_q[winner].cmd;
               br_addr_d      = slot_q[winner].addr;
               br_wr_data_d   = slot_q[winner].data;
               br_data_mask_d = slot_q[winner].mask;
               owner_d        = winner;
               last_grant_d   = winner;
               state_d        = slot_q[winner].cmd ? WRITE : READ;
            end
         end
         READ: begin
            if (br_rd_data_valid) begin
               if (beat_cnt_q == LAST) begin
                  beat_cnt_d          = '0;
                  slot_vld_d[owner_q] = 1'b0;
                  state_d             = IDLE;
               end else begin
                  beat_cnt_d = beat_cnt_q + CW'(1);
               end
            end
         end
         WRITE: begin
            // beat_cnt counts wr_next strobes issued; the beat arrives one cycle behind its strobe.
            if (wr_next_q) br_wr_data_d = wr_data_in[owner_q];
            if (beat_cnt_q < LAST) begin
               wr_next_d  = 1'b1;
               beat_cnt_d = beat_cnt_q + CW'(1);
            end else if (wr_next_q || LAST == '0) begin
               beat_cnt_d = '0;
               state_d    = DRAIN;
            end
         end
         DRAIN: begin
            if (!br_busy) begin
               slot_vld_d[owner_q] = 1'b0;
               state_d             = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!rst_n) begin
         state_q        <= IDLE;
         owner_q        <= 1'b0;
         last_grant_q   <= 1'b1;
         beat_cnt_q     <= '0;
         wr_next_q      <= 1'b0;
         slot_vld_q     <= '0;
         br_cmd_q       <= 1'b0;
         br_cmd_en_q    <= 1'b0;
         br_addr_q      <= '0;
         br_wr_data_q   <= '0;
         br_data_mask_q <= '0;
      end else begin
         state_q        <= state_d;
         owner_q        <= owner_d;
         last_grant_q   <= last_grant_d;
         beat_cnt_q     <= beat_cnt_d;
         wr_next_q      <= wr_next_d;
         slot_vld_q     <= slot_vld_d;
         br_cmd_q       <= br_cmd_d;
         br_cmd_en_q    <= br_cmd_en_d;
         br_addr_q      <= br_addr_d;
         br_wr_data_q   <= br_wr_data_d;
         br_data_mask_q <= br_data_mask_d;
      end
   end

   // NOTE: request payload has no reset; it is only read while its valid bit is set.
   always_ff @(posedge clk) slot_q <= slot_d;

   assign p0_rd_data       = br_rd_data;
   assign p1_rd_data       = br_rd_data;
   assign p0_rd_data_valid = br_rd_data_valid && (state_q == READ) && !owner_q;
   assign p1_rd_data_valid = br_rd_data_valid && (state_q == READ) && owner_q;
   assign p0_wr_next       = wr_next_q && !owner_q;
   assign p1_wr_next       = wr_next_q && owner_q;
   assign p0_busy          = slot_vld_q[0];
   assign p1_busy          = slot_vld_q[1];
   assign br_cmd           = br_cmd_q;
   assign br_cmd_en        = br_cmd_en_q;
   assign br_addr          = br_addr_q;
   assign br_wr_data       = br_wr_data_q;
   assign br_data_mask     = br_data_mask_q;
endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Directed self-checking bench for burst_ram_arbiter; one task per scenario.
// Honors BURST_ARB_FIXED_PRIO_EN when the same macro is defined for the design.
module tb_burst_ram_arbiter;
   localparam int DW = 64;
   localparam int AW = 8;
   localparam int MW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          p0_cmd = 1'b0, p0_cmd_en = 1'b0, p1_cmd = 1'b0, p1_cmd_en = 1'b0;
   logic [AW-1:0] p0_addr = '0, p1_addr = '0;
   logic [DW-1:0] p0_wr_data = '0, p1_wr_data = '0;
   logic [MW-1:0] p0_data_mask = '0, p1_data_mask = '0;
   logic          p0_wr_next, p1_wr_next, p0_rd_data_valid, p1_rd_data_valid, p0_busy, p1_busy;
   logic [DW-1:0] p0_rd_data, p1_rd_data;
   logic          br_cmd, br_cmd_en;
   logic [AW-1:0] br_addr;
   logic [DW-1:0] br_wr_data;
   logic [MW-1:0] br_data_mask;
   logic [DW-1:0] br_rd_data = '0;
   logic          br_rd_data_valid = 1'b0, br_busy = 1'b0;

   int errors = 0;
   int checks = 0;

   burst_ram_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .p0_cmd(p0_cmd), .p0_cmd_en(p0_cmd_en), .p0_addr(p0_addr), .p0_wr_data(p0_wr_data),
      .p0_data_mask(p0_data_mask), .p0_wr_next(p0_wr_next), .p0_rd_data(p0_rd_data),
      .p0_rd_data_valid(p0_rd_data_valid), .p0_busy(p0_busy),
      .p1_cmd(p1_cmd), .p1_cmd_en(p1_cmd_en), .p1_addr(p1_addr), .p1_wr_data(p1_wr_data),
      .p1_data_mask(p1_data_mask), .p1_wr_next(p1_wr_next), .p1_rd_data(p1_rd_data),
      .p1_rd_data_valid(p1_rd_data_valid), .p1_busy(p1_busy),
      .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr), .br_wr_data(br_wr_data),
      .br_data_mask(br_data_mask), .br_rd_data(br_rd_data),
      .br_rd_data_valid(br_rd_data_valid), .br_busy(br_busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   // Plays the RAM side of a 4-beat read, starting the cycle after br_cmd_en.
   task automatic drive_read_burst(input bit port, input logic [DW-1:0] base);
      logic [DW-1:0] beat;
      step();
      for (int i = 0; i < 4; i++) begin
         beat             = base + DW'(i);
         br_rd_data       = beat;
         br_rd_data_valid = 1'b1;
         #1;
         checks++;
         if ((port ? p1_rd_data_valid : p0_rd_data_valid) !== 1'b1 ||
             (port ? p0_rd_data_valid : p1_rd_data_valid) !== 1'b0) begin
            errors++;
            $display("FAIL rd_valid p%0d beat%0d: p0=%b p1=%b, want only p%0d high",
                     port, i, p0_rd_data_valid, p1_rd_data_valid, port);
         end
         checks++;
         if ((port ? p1_rd_data : p0_rd_data) !== beat) begin
            errors++;
            $display("FAIL rd_data p%0d beat%0d: got %h want %h", port, i,
                     port ? p1_rd_data : p0_rd_data, beat);
         end
         checks++;
         if ((port ? p1_busy : p0_busy) !== 1'b1) begin
            errors++;
            $display("FAIL busy_during_burst p%0d beat%0d: got 0 want 1", port, i);
         end
         step();
      end
      br_rd_data_valid = 1'b0;
      checks++;
      if ((port ? p1_busy : p0_busy) !== 1'b0) begin
         errors++;
         $display("FAIL busy_after_burst p%0d: got 1 want 0", port);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      checks++;
      if ({br_cmd, br_cmd_en, br_addr, br_data_mask, p0_busy, p1_busy, p0_wr_next, p1_wr_next} !== '0) begin
         errors++;
         $display("FAIL reset_ctrl: cmd=%b en=%b addr=%h mask=%h busy=%b%b wr_next=%b%b, want all 0",
                  br_cmd, br_cmd_en, br_addr, br_data_mask, p0_busy, p1_busy, p0_wr_next, p1_wr_next);
      end
      checks++;
      if (br_wr_data !== '0) begin
         errors++;
         $display("FAIL reset_wr_data: got %h want 0", br_wr_data);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_single_read();
      p1_cmd = 1'b0; p1_addr = 8'h10; p1_cmd_en = 1'b1;
      step();
      p1_cmd_en = 1'b0;
      checks++;
      if ({p1_busy, br_cmd_en} !== 2'b10) begin
         errors++;
         $display("FAIL read_t1: busy=%b cmd_en=%b, want busy=1 cmd_en=0", p1_busy, br_cmd_en);
      end
      step();
      checks++;
      if ({br_cmd_en, br_cmd, br_addr} !== {1'b1, 1'b0, 8'h10}) begin
         errors++;
         $display("FAIL read_issue: en=%b cmd=%b addr=%h, want 1/0/10", br_cmd_en, br_cmd, br_addr);
      end
      drive_read_burst(1'b1, 64'hA0A0_0000_0000_0001);
   endtask

   task automatic test_contention();
      do_reset();
      p0_cmd = 1'b0; p0_addr = 8'h30; p0_cmd_en = 1'b1;
      p1_cmd = 1'b0; p1_addr = 8'h40; p1_cmd_en = 1'b1;
      step();
      p0_cmd_en = 1'b0; p1_cmd_en = 1'b0;
      step();
      checks++;
      if ({br_cmd_en, br_addr, p1_busy} !== {1'b1, 8'h30, 1'b1}) begin
         errors++;
         $display("FAIL contention_first: en=%b addr=%h p1_busy=%b, want 1/30/1", br_cmd_en, br_addr, p1_busy);
      end
      drive_read_burst(1'b0, 64'hC0C0_0000_0000_0010);
      checks++;
      if (br_cmd_en !== 1'b0) begin
         errors++;
         $display("FAIL contention_gap: cmd_en=%b want 0", br_cmd_en);
      end
      step();
      checks++;
      if ({br_cmd_en, br_addr} !== {1'b1, 8'h40}) begin
         errors++;
         $display("FAIL contention_second: en=%b addr=%h, want 1/40", br_cmd_en, br_addr);
      end
      drive_read_burst(1'b1, 64'hD0D0_0000_0000_0020);
   endtask

   task automatic test_write();
      int next_beat;
      int wn_cnt;
      p0_cmd = 1'b1; p0_addr = 8'h20; p0_wr_data = 64'd1; p0_data_mask = 8'hFF; p0_cmd_en = 1'b1;
      step();
      p0_cmd_en = 1'b0; p0_wr_data = '0;
      step();
      checks++;
      if ({br_cmd_en, br_cmd, br_addr, br_data_mask} !== {1'b1, 1'b1, 8'h20, 8'hFF}) begin
         errors++;
         $display("FAIL write_issue: en=%b cmd=%b addr=%h mask=%h, want 1/1/20/ff",
                  br_cmd_en, br_cmd, br_addr, br_data_mask);
      end
      checks++;
      if (br_wr_data !== 64'd1) begin
         errors++;
         $display("FAIL write_beat0: got %h want 1", br_wr_data);
      end
      br_busy   = 1'b1;
      next_beat = 2;
      wn_cnt    = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (p0_wr_next === 1'b1) begin
            wn_cnt++;
            p0_wr_data = DW'(next_beat);
            next_beat++;
         end
         checks++;
         if (br_wr_data !== DW'(i + 1)) begin
            errors++;
            $display("FAIL write_data cyc%0d: got %h want %0d", i, br_wr_data, i + 1);
         end
         checks++;
         if ({p0_wr_next, p1_wr_next} !== {(i < 3), 1'b0}) begin
            errors++;
            $display("FAIL write_next cyc%0d: p0=%b p1=%b want p0=%b p1=0", i, p0_wr_next, p1_wr_next, (i < 3));
         end
      end
      checks++;
      if (wn_cnt != 3) begin
         errors++;
         $display("FAIL write_next_count: got %0d want 3", wn_cnt);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({p0_busy, p0_wr_next} !== 2'b10) begin
            errors++;
            $display("FAIL drain_hold cyc%0d: busy=%b wr_next=%b want 1/0", i, p0_busy, p0_wr_next);
         end
      end
      br_busy = 1'b0;
      step();
      checks++;
      if (p0_busy !== 1'b0) begin
         errors++;
         $display("FAIL drain_release: p0_busy=%b want 0", p0_busy);
      end
      p0_cmd = 1'b0;
   endtask

   task automatic test_br_busy_hold();
      br_busy = 1'b1;
      p1_cmd = 1'b0; p1_addr = 8'h55; p1_cmd_en = 1'b1;
      step();
      p1_cmd_en = 1'b0;
      p1_addr   = 8'h00;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (br_cmd_en !== 1'b0) begin
            errors++;
            $display("FAIL busy_hold cyc%0d: cmd_en=%b want 0", i, br_cmd_en);
         end
         if (i < 4) step();
      end
      br_busy = 1'b0;
      step();
      checks++;
      if ({br_cmd_en, br_addr} !== {1'b1, 8'h55}) begin
         errors++;
         $display("FAIL busy_release_issue: en=%b addr=%h want 1/55", br_cmd_en, br_addr);
      end
      drive_read_burst(1'b1, 64'hB0B0_0000_0000_0030);
   endtask

   task automatic test_round_robin();
      bit exp_w [4];
`ifdef BURST_ARB_FIXED_PRIO_EN
      exp_w = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
      exp_w = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
      do_reset();
      br_busy = 1'b1;
      p0_cmd = 1'b0; p0_addr = 8'h60; p0_cmd_en = 1'b1;
      p1_cmd = 1'b0; p1_addr = 8'h70; p1_cmd_en = 1'b1;
      for (int r = 0; r < 4; r++) begin
         step();
         p0_cmd_en = 1'b0; p1_cmd_en = 1'b0; br_busy = 1'b0;
         step();
         checks++;
         if ({br_cmd_en, br_addr} !== {1'b1, exp_w[r] ? 8'h70 : 8'h60}) begin
            errors++;
            $display("FAIL rr_round%0d: en=%b addr=%h want grant to p%0d", r, br_cmd_en, br_addr, exp_w[r]);
         end
         br_busy = 1'b1;
         drive_read_burst(exp_w[r], 64'hF000 + DW'(r * 16));
         if (r < 3) begin
            if (exp_w[r]) p1_cmd_en = 1'b1;
            else          p0_cmd_en = 1'b1;
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      br_busy = 1'b0;
      p1_cmd = 1'b0; p1_addr = 8'h11; p1_cmd_en = 1'b1;
      step();
      p1_cmd_en = 1'b0;
      step();
      step();
      br_rd_data = 64'h1111; br_rd_data_valid = 1'b1;
      step();
      br_rd_data = 64'h2222;
      rst_n      = 1'b0;
      step();
      rst_n = 1'b1;
      br_rd_data_valid = 1'b0;
      #1;
      checks++;
      if ({br_cmd, br_cmd_en, br_addr, br_data_mask, p0_busy, p1_busy, p0_wr_next, p1_wr_next,
           p0_rd_data_valid, p1_rd_data_valid} !== '0 || br_wr_data !== '0) begin
         errors++;
         $display("FAIL mid_reset_outputs: en=%b addr=%h busy=%b%b wr_next=%b%b rdv=%b%b, want all 0",
                  br_cmd_en, br_addr, p0_busy, p1_busy, p0_wr_next, p1_wr_next,
                  p0_rd_data_valid, p1_rd_data_valid);
      end
      p1_addr = 8'h12; p1_cmd_en = 1'b1;
      step();
      p1_cmd_en = 1'b0;
      step();
      checks++;
      if ({br_cmd_en, br_addr} !== {1'b1, 8'h12}) begin
         errors++;
         $display("FAIL post_reset_issue: en=%b addr=%h want 1/12", br_cmd_en, br_addr);
      end
      drive_read_burst(1'b1, 64'hE0E0_0000_0000_0040);
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_contention();
      test_write();
      test_br_busy_hold();
      test_round_robin();
      test_reset_mid_burst();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
